// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 restoring divider.
package div_pkg;

    // Operation encoding as presented by the execute stage.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_e;

    localparam int unsigned DIV_XLEN = 32;

    // Iteration counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned xlen);
        return (xlen < 2) ? 1 : $clog2(xlen);
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_XLEN);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            qbit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            quo_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] dvs_ext;
    logic [XLEN:0] diff;
    logic          unused_rem_msb;

    // The remainder MSB is always shifted out; it never holds information
    // because the partial remainder stays below the divisor.
    assign unused_rem_msb = rem_i[XLEN];

    // Trial subtraction with restore when the divisor does not fit.
    always_comb begin
        shifted   = {rem_i[XLEN-1:0], qbit_i};
        dvs_ext   = {1'b0, divisor_i};
        diff      = shifted - dvs_ext;
        quo_bit_o = (shifted >= dvs_ext);
        rem_o     = quo_bit_o ? diff : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; start pulse in, single-cycle valid pulse out.
// Optional macro SEQ_DIVIDER_FASTPATH_EN: divide-by-zero and signed overflow
// skip the iterations and go straight to FIXUP. Results are identical.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CNT_W    = cnt_width(XLEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0] ZERO     = '0;
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic            dvd_sign_q, dvd_sign_d;
    logic            dvs_sign_q, dvs_sign_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_signed;
    logic            in_div_zero;
    logic            in_ovf;
    logic [XLEN-1:0] in_dividend_abs;
    logic [XLEN-1:0] in_divisor_abs;
    logic [XLEN:0]   step_rem;
    logic            step_bit;
    logic            fix_signed;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .qbit_i    (quo_q[XLEN-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_bit_o (step_bit)
    );

    // Operand preparation at launch: magnitudes for signed ops, special cases.
    always_comb begin
        in_signed       = ~op_i[0];
        in_div_zero     = (divisor_i == ZERO);
        in_ovf          = in_signed && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
        in_dividend_abs = (in_signed && dividend_i[XLEN-1]) ? (ZERO - dividend_i) : dividend_i;
        in_divisor_abs  = (in_signed && divisor_i[XLEN-1]) ? (ZERO - divisor_i) : divisor_i;
    end

    // Sign correction and special-case override of the raw quotient/remainder.
    always_comb begin
        fix_signed = ~op_q[0];
        quo_fix    = (fix_signed && (dvd_sign_q ^ dvs_sign_q)) ? (ZERO - quo_q) : quo_q;
        rem_fix    = (fix_signed && dvd_sign_q) ? (ZERO - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        if (div_zero_q) begin
            quo_fix = ALL_ONES;
            rem_fix = dividend_q;
        end else if (ovf_q) begin
            quo_fix = dividend_q;
            rem_fix = ZERO;
        end
        fix_result = op_q[1] ? rem_fix : quo_fix;
    end

    // Register update for FSM state and the whole datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= DIV;
            dvd_sign_q <= 1'b0;
            dvs_sign_q <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dvd_sign_q <= dvd_sign_d;
            dvs_sign_q <= dvs_sign_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    // Next-state logic; a flush always returns to IDLE and beats a start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef SEQ_DIVIDER_FASTPATH_EN
                    state_d = (in_div_zero || in_ovf) ? FIXUP : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (cnt_q == '0) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    // Datapath next values: load at launch, iterate in CALC, capture in FIXUP.
    always_comb begin
        op_d       = op_q;
        dvd_sign_d = dvd_sign_q;
        dvs_sign_d = dvs_sign_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        if (!kill_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_d       = div_op_e'(op_i);
                        dvd_sign_d = dividend_i[XLEN-1];
                        dvs_sign_d = divisor_i[XLEN-1];
                        div_zero_d = in_div_zero;
                        ovf_d      = in_ovf;
                        dividend_d = dividend_i;
                        divisor_d  = in_divisor_abs;
                        quo_d      = in_dividend_abs;
                        rem_d      = '0;
                        cnt_d      = CNT_INIT;
                    end
                end
                CALC: begin
                    quo_d = {quo_q[XLEN-2:0], step_bit};
                    rem_d = step_rem;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                end
                FIXUP:   result_d = fix_result;
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_o   = (state_q != IDLE);
        valid_o  = (state_q == DONE);
        result_o = result_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (XLEN=32).
// Honours SEQ_DIVIDER_FASTPATH_EN for the expected special-case latency.
module tb_seq_divider;

    localparam int NORM_LAT = 34;
`ifdef SEQ_DIVIDER_FASTPATH_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 34;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        int          lat;
        string       tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    vec_t vecs [0:13];

    seq_divider #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .kill_i     (kill),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cycle    = 1;
    endtask

    task automatic waitValid(output logic [31:0] res, output int lat, output int busyLow);
        lat     = -1;
        busyLow = 0;
        res     = '0;
        while (cycle <= 80) begin
            if (!busy) busyLow++;
            if (valid) begin
                lat = cycle;
                res = result;
                break;
            end
            step();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] res;
        int          lat;
        int          busyLow;
        launch(v.op, v.a, v.b);
        waitValid(res, lat, busyLow);
        checkOutput({v.tag, "_result"}, res, v.expv);
        checkOutput({v.tag, "_latency"}, lat, v.lat);
        checkOutput({v.tag, "_busy_gap"}, busyLow, 0);
        step();
        checkOutput({v.tag, "_idle_after"}, {30'd0, busy, valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          busyLow;
        int          validSeen;

        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        NORM_LAT, "divu_100_7"};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         NORM_LAT, "remu_100_7"};
        vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  NORM_LAT, "div_m100_7"};
        vecs[3]  = '{2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  NORM_LAT, "rem_m100_7"};
        vecs[4]  = '{2'b10, 32'd100,       32'hFFFFFFF9,  32'd2,         NORM_LAT, "rem_100_m7"};
        vecs[5]  = '{2'b00, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         NORM_LAT, "div_m7_m2"};
        vecs[6]  = '{2'b10, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF,  NORM_LAT, "rem_m7_m2"};
        vecs[7]  = '{2'b00, 32'd5,         32'd0,         32'hFFFFFFFF,  SPEC_LAT, "div_5_0"};
        vecs[8]  = '{2'b11, 32'd5,         32'd0,         32'd5,         SPEC_LAT, "remu_5_0"};
        vecs[9]  = '{2'b10, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  SPEC_LAT, "rem_m5_0"};
        vecs[10] = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  SPEC_LAT, "div_ovf"};
        vecs[11] = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         SPEC_LAT, "rem_ovf"};
        vecs[12] = '{2'b01, 32'h80000000,  32'hFFFFFFFF,  32'd0,         NORM_LAT, "divu_big"};
        vecs[13] = '{2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  NORM_LAT, "remu_big"};

        rst      = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // start pulse while busy is ignored; start in DONE ignored, next cycle accepted
        launch(2'b01, 32'd100, 32'd7);
        while (cycle < 5) step();
        op = 2'b01; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        waitValid(res, lat, busyLow);
        checkOutput("busy_start_result", res, 32'd14);
        checkOutput("busy_start_latency", lat, NORM_LAT);
        start = 1'b1;
        step();
        checkOutput("done_start_ignored", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        checkOutput("after_done_accept", {31'd0, busy}, 32'd1);
        cycle = 1;
        waitValid(res, lat, busyLow);
        checkOutput("after_done_result", res, 32'd3);
        checkOutput("after_done_latency", lat, NORM_LAT);
        step();

        // kill mid-operation, then immediate restart
        launch(2'b01, 32'd1000, 32'd3);
        while (cycle < 10) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        checkOutput("kill_busy", {31'd0, busy}, 32'd0);
        checkOutput("kill_valid", {31'd0, valid}, 32'd0);
        checkOutput("kill_result_hold", result, 32'd3);
        applyStimulus('{2'b01, 32'd9, 32'd3, 32'd3, NORM_LAT, "restart_divu_9_3"});

        // synchronous reset mid-operation
        launch(2'b01, 32'd100, 32'd7);
        while (cycle < 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        validSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) validSeen++;
            step();
        end
        checkOutput("midrst_no_valid", validSeen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Inverse operation to the combinational Wallace multiply path.
- Sits beside the multiplier in the mul_div unit. The execute stage launches it with a start pulse and it returns a single-cycle valid pulse.
- Trades area for latency: one quotient bit is resolved per clock.

Parameters:
- XLEN, 32, operand/result width; must be at least 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  launch request; sampled only in IDLE.
- kill_i  in  1  pipeline flush; aborts any operation.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  XLEN  rs1 value.
- divisor_i  in  XLEN  rs2 value.
- busy_o  out  1  high whenever state is not IDLE.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  quotient or remainder; valid only while valid_o is high.

Behaviour:
- Reset: state is IDLE. busy_o=0, valid_o=0, result_o=0, and all internal registers are 0. rst_i mid-operation discards the operation and produces no valid_o.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On start_i with kill_i low: latch op, the signs, |dividend| and |divisor| (absolute values only for DIV/REM; raw values otherwise).
  - Clear the partial remainder (XLEN+1 bits), load cnt=XLEN-1, go to CALC.
- CALC, each cycle:
  - rem' = {rem[XLEN-1:0], quo[XLEN-1]}.
  - If rem' >= {0,divisor}: rem = rem' - divisor and shift 1 into quo; otherwise rem = rem' and shift in 0.
  - When cnt==0, go to FIXUP; otherwise decrement cnt.
- FIXUP: compute the final value and register it into result_o, then go to DONE.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones and remainder = dividend, for both signed and unsigned ops.
  - Signed overflow (dividend=-2^(XLEN-1), divisor=-1): quotient = dividend, remainder = 0.
- DONE: valid_o=1 for exactly one cycle, then go to IDLE. start_i is ignored in DONE.
- Latency: with start sampled at edge 0, CALC occupies cycles 1..XLEN, FIXUP is cycle XLEN+1, and valid_o is high in cycle XLEN+2 (cycle 34 for XLEN=32).
- Throughput: the next start is accepted in the cycle after DONE.
- start_i while busy_o=1 is ignored; no queueing.
- kill_i in any state: next state is IDLE, valid_o stays low, result_o holds its old value. kill_i wins over a simultaneous start_i.
- result_o holds its last value outside DONE; consumers sample only while valid_o is high.

Optional Feature:
- Macro: SEQ_DIVIDER_FASTPATH_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE at start. The FSM goes IDLE→FIXUP→DONE, so valid_o is high in cycle 2 after start with the special-case result.
- Undefined: these cases run the full XLEN iterations. FIXUP forces the same architectural results, with valid_o at cycle XLEN+2.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package div_pkg holds:
  - div_op_e (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11);
  - div_state_e (IDLE, CALC, FIXUP, DONE);
  - the localparam for counter width, $clog2(XLEN).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, next quotient bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once in CALC.

Test Plan:
- DIVU 100/7: valid_o at cycle 34, result 14. REMU 100/7 → 2. busy_o high cycles 1..34.
- DIV -100/7 → 0xFFFFFFF2 (-14). REM -100/7 → 0xFFFFFFFE (-2). REM 100/-7 → 2.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Latency 34 without the macro, 2 with SEQ_DIVIDER_FASTPATH_EN.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Launch DIVU, assert kill_i at cycle 10 → busy_o low at cycle 11, no valid_o. Immediate restart DIVU 9/3 → result 3 with normal latency.
- Assert rst_i at cycle 20 of an operation → all outputs 0 next cycle. A start_i pulse during busy is ignored and the original result is unaffected.
